// File: rtl/core_task_frontend_pkg.sv
// Shared definitions for the per-core task frontend.
//   - Default geometry of the scheduler buses and the instruction frame.
//   - FSM state encoding.
//   - Helper that locates a core's R0 slice on the packed R0-init bus.
package core_task_frontend_pkg;

    localparam int NUM_OF_CORES   = 4;   // cores on the scheduler buses
    localparam int INSN_LOAD_TIME = 4;   // bus words per frame, power of 2
    localparam int INSN_WIDTH     = 16;  // instruction width
    localparam int INSNS_PER_WORD = 4;   // instructions per bus word, power of 2
    localparam int REG_WIDTH      = 8;   // R0 width
    localparam int PC_WIDTH       = 5;   // fetch pc width

    typedef enum logic {
        ST_IDLE = 1'b0,   // waiting for a start, ready to the scheduler
        ST_RUN  = 1'b1    // pipeline executing the active frame
    } fe_state_t;

    // LSB of core_idx's R0 value on the packed init bus.
    function automatic int r0_slice_lsb(input int core_idx, input int reg_w);
        return core_idx * reg_w;
    endfunction

endpackage

// File: rtl/core_frame_buffer.sv
// Instruction frame storage for one core.
//   Snoops the broadcast frame bus into a shadow copy and, on commit, copies
//   the shadow into the active copy the pipeline fetches from.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   insn_load_cnt  scheduler load counter (word index of the NEXT cycle's data)
//   insn_data      broadcast frame word
//   commit         copy shadow -> active this edge
//   rd_pc          instruction index within the frame
//   rd_insn        addressed instruction from the active copy (0 when out of range)
//   rd_oob         rd_pc lies beyond the frame
module core_frame_buffer #(
    parameter int LOAD_TIME      = 4,
    parameter int INSN_W         = 16,
    parameter int INSNS_PER_WORD = 4,
    parameter int PC_W           = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [$clog2(LOAD_TIME)-1:0]       insn_load_cnt,
    input  logic [INSN_W*INSNS_PER_WORD-1:0]   insn_data,
    input  logic                               commit,
    input  logic [PC_W-1:0]                    rd_pc,
    output logic [INSN_W-1:0]                  rd_insn,
    output logic                               rd_oob
);

    localparam int CNT_W       = $clog2(LOAD_TIME);
    localparam int LANE_W      = $clog2(INSNS_PER_WORD);
    localparam int WORD_W      = INSN_W * INSNS_PER_WORD;
    localparam int FRAME_INSNS = LOAD_TIME * INSNS_PER_WORD;

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] shadow [LOAD_TIME];
    logic [WORD_W-1:0] active [LOAD_TIME];

    // Bus data lags the counter by one cycle, so the delayed counter is the
    // slot the current insn_data belongs to.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_W'(LOAD_TIME - 1);
        end else begin
            cnt_q <= insn_load_cnt;
        end
    end

    // NOTE: the frame arrays are plain storage with no reset; their contents
    // are meaningless until a frame is loaded and committed, and leaving them
    // unreset lets them map onto RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow[cnt_q] <= insn_data;
        end
    end

    // The slot being written this very edge is taken straight from the bus,
    // otherwise a start coinciding with the last word would commit stale data.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < LOAD_TIME; i++) begin
                active[i] <= (CNT_W'(i) == cnt_q) ? insn_data : shadow[i];
            end
        end
    end

    logic [CNT_W-1:0]  rd_word;
    logic [LANE_W-1:0] rd_lane;

    assign rd_word = rd_pc[LANE_W +: CNT_W];
    assign rd_lane = rd_pc[LANE_W-1:0];
    assign rd_oob  = {1'b0, rd_pc} >= (PC_W + 1)'(FRAME_INSNS);
    assign rd_insn = rd_oob ? '0 : active[rd_word][rd_lane*INSN_W +: INSN_W];

endmodule

// File: rtl/core_task_frontend.sv
// Per-core receive stage downstream of the task scheduler.
//   Keeps a shadow of the broadcast instruction frame, commits it to the
//   active buffer on this core's start pulse, captures the initial R0, serves
//   pipeline fetches and drives the ready handshake back to the scheduler.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   insn_load_cnt   scheduler load counter
//   insn_data       broadcast frame word
//   start_vec       one-cycle start pulses, bit CORE_IDX is ours
//   init_r0_vect    per-core R0-init enables (level)
//   init_r0_bus     packed per-core R0 values
//   fetch_req       pipeline fetch strobe
//   fetch_pc        instruction index within the frame
//   core_done       pipeline finished the frame (pulse)
//   ready           idle and able to accept a frame
//   core_run        pipeline enable
//   fetch_valid     fetch_insn/fetch_oob valid (one cycle after fetch_req)
//   fetch_insn      fetched instruction (0 when out of range)
//   fetch_oob       fetch_pc was beyond the frame
//   r0_load         one-cycle R0 write strobe
//   r0_value        value for R0
//   proto_err       sticky protocol-violation flag, cleared only by reset
module core_task_frontend
    import core_task_frontend_pkg::*;
#(
    parameter int CORE_IDX       = 0,
    parameter int NUM_CORES      = NUM_OF_CORES,
    parameter int LOAD_TIME      = INSN_LOAD_TIME,
    parameter int INSN_W         = INSN_WIDTH,
    parameter int INSNS_PER_WORD = core_task_frontend_pkg::INSNS_PER_WORD,
    parameter int REG_W          = REG_WIDTH,
    parameter int PC_W           = PC_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(LOAD_TIME)-1:0]     insn_load_cnt,
    input  logic [INSN_W*INSNS_PER_WORD-1:0] insn_data,
    input  logic [NUM_CORES-1:0]             start_vec,
    input  logic [NUM_CORES-1:0]             init_r0_vect,
    input  logic [NUM_CORES*REG_W-1:0]       init_r0_bus,
    input  logic                             fetch_req,
    input  logic [PC_W-1:0]                  fetch_pc,
    input  logic                             core_done,
    output logic                             ready,
    output logic                             core_run,
    output logic                             fetch_valid,
    output logic [INSN_W-1:0]                fetch_insn,
    output logic                             fetch_oob,
    output logic                             r0_load,
    output logic [REG_W-1:0]                 r0_value,
    output logic                             proto_err
);

    localparam int R0_LSB = r0_slice_lsb(CORE_IDX, REG_W);

    fe_state_t         state_q, state_d;
    logic              start_me;
    logic              accept_start;
    logic              proto_viol;
    logic              fetch_hit;
    logic [INSN_W-1:0] rd_insn;
    logic              rd_oob;

    assign start_me  = start_vec[CORE_IDX];
    assign fetch_hit = (state_q == ST_RUN) && fetch_req;

    // Other cores' slices of the shared buses are deliberately ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{start_vec, init_r0_vect, init_r0_bus};

    core_frame_buffer #(
        .LOAD_TIME      (LOAD_TIME),
        .INSN_W         (INSN_W),
        .INSNS_PER_WORD (INSNS_PER_WORD),
        .PC_W           (PC_W)
    ) u_frame_buffer (
        .clk           (clk),
        .reset         (reset),
        .insn_load_cnt (insn_load_cnt),
        .insn_data     (insn_data),
        .commit        (accept_start),
        .rd_pc         (fetch_pc),
        .rd_insn       (rd_insn),
        .rd_oob        (rd_oob)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        proto_viol   = 1'b0;
        ready        = 1'b0;
        core_run     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start_me) begin
                    accept_start = 1'b1;
                    state_d      = ST_RUN;
                end
                if (fetch_req) begin
                    proto_viol = 1'b1;
                end
            end
            ST_RUN: begin
                core_run = 1'b1;
                // A start while running is dropped, even when done arrives
                // in the same cycle: done wins.
                if (core_done) begin
                    state_d = ST_IDLE;
                end
                if (start_me) begin
                    proto_viol = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fetch_valid <= 1'b0;
            fetch_insn  <= '0;
            fetch_oob   <= 1'b0;
            r0_load     <= 1'b0;
            r0_value    <= '0;
            proto_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_valid <= fetch_hit;
            fetch_insn  <= fetch_hit ? rd_insn : '0;
            fetch_oob   <= fetch_hit && rd_oob;
            r0_load     <= accept_start && init_r0_vect[CORE_IDX];
            if (accept_start && init_r0_vect[CORE_IDX]) begin
                r0_value <= init_r0_bus[R0_LSB +: REG_W];
            end
            if (proto_viol) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
